// File: rtl/exc_cp0.sv
// exc_cp0: exception select/commit and CP0 register file (optional TIMER_INT_EN adds Count/Compare timer)
module exc_cp0 #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] PRID_VALUE = 32'h00004220
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adelM,
    input  logic        adesM,
    input  logic [31:0] addrsM,
    input  logic [31:0] pcM,
    input  logic        is_in_delayslotM,
    input  logic        syscallM,
    input  logic        breakM,
    input  logic        eretM,
    input  logic        riM,
    input  logic        overflowM,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic [4:0]  excepttype_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);
    logic [7:0]  im;
    logic        exl, ie, bd;
    logic [4:0]  excCode;
    logic [5:0]  ipHw;
    logic [1:0]  ipSw;
    logic [31:0] epc, badVAddr, count, compare;
    logic        timerInt, intPend, misalign, isExc, selAddrErr;
    logic [4:0]  selCode;
    logic        wrStatus, wrCause, wrEpc;

    assign wrStatus = we_i && waddr_i == 5'd12;
    assign wrCause  = we_i && waddr_i == 5'd13;
    assign wrEpc    = we_i && waddr_i == 5'd14;
    assign status_o = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause_o  = {bd, 15'b0, ipHw, ipSw, 1'b0, excCode, 2'b0};
    assign epc_o    = epc;
    assign intPend  = ie & ~exl & |({ipHw, ipSw} & im);
    assign misalign = pcM[1:0] != 2'b00;

    // priority select of the exception source and redirect target
    always_comb begin
        selCode = intPend ? 5'h00 : misalign ? 5'h04 : riM ? 5'h0A : overflowM ? 5'h0C :
                  syscallM ? 5'h08 : breakM ? 5'h09 : adelM ? 5'h04 : adesM ? 5'h05 : 5'h1F;
        isExc = intPend | misalign | riM | overflowM | syscallM | breakM | adelM | adesM;
        selAddrErr = ~(intPend | misalign | riM | overflowM | syscallM | breakM) & (adelM | adesM);
        flush_o = isExc | eretM;
        excepttype_o = flush_o ? selCode : 5'h00;
        newpc_o = isExc ? EXC_VECTOR : epc;
    end

    // mfc0 read mux, no bypass of same-cycle writes
    always_comb begin
        rdata_o = 32'h0;
        case (raddr_i)
            5'd8:  rdata_o = badVAddr;
            5'd9:  rdata_o = count;
            5'd11: rdata_o = compare;
            5'd12: rdata_o = status_o;
            5'd13: rdata_o = cause_o;
            5'd14: rdata_o = epc;
            5'd15: rdata_o = PRID_VALUE;
            default: rdata_o = 32'h0;
        endcase
    end

    // mtc0 writes first, exception/eret updates override the fields they touch
    always_ff @(posedge clk) begin
        if (rst) begin
            im <= 8'h0;
            exl <= 1'b0;
            ie <= 1'b0;
            bd <= 1'b0;
            excCode <= 5'h0;
            ipHw <= 6'h0;
            ipSw <= 2'h0;
            epc <= 32'h0;
            badVAddr <= 32'h0;
        end else begin
            ipHw <= {int_i[5] | timerInt, int_i[4:0]};
            if (wrCause) ipSw <= wdata_i[9:8];
            if (wrEpc) epc <= wdata_i;
            if (wrStatus) begin
                im <= wdata_i[15:8];
                exl <= wdata_i[1];
                ie <= wdata_i[0];
            end
            if (isExc) begin
                excCode <= selCode;
                exl <= 1'b1;
                if (!exl) begin
                    epc <= is_in_delayslotM ? pcM - 32'd4 : pcM;
                    bd <= is_in_delayslotM;
                end
                if (selCode == 5'h04 && misalign && !intPend) badVAddr <= pcM;
                else if (selAddrErr) badVAddr <= addrsM;
            end else if (eretM) begin
                exl <= 1'b0;
            end
        end
    end

`ifdef TIMER_INT_EN
    logic tick;
    logic wrCount, wrCompare;
    assign wrCount   = we_i && waddr_i == 5'd9;
    assign wrCompare = we_i && waddr_i == 5'd11;

    // Count advances every other cycle; timer latches on match until Compare is rewritten
    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= 1'b0;
            count <= 32'h0;
            compare <= 32'h0;
            timerInt <= 1'b0;
        end else begin
            tick <= ~tick;
            count <= wrCount ? wdata_i : count + {31'b0, tick};
            if (wrCompare) compare <= wdata_i;
            timerInt <= wrCompare ? 1'b0 : timerInt | (count == compare && compare != 32'h0);
        end
    end
`else
    assign count    = 32'h0;
    assign compare  = 32'h0;
    assign timerInt = 1'b0;
`endif
endmodule
